// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (output req_i, we_i, addr_i, wdata_i, be_i,
                   input  gnt_o, rvalid_o, rdata_o, err_o);
   modport slave  (input  req_i, we_i, addr_i, wdata_i, be_i,
                   output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: req/gnt accept, WAIT_CYCLES wait states, byte-masked write or word read.
// Optional macro DMEM_BACK2BACK_EN: grant also in RESP so a new request skips IDLE.
module dmem_responder #(
   parameter int N           = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
   localparam state_t     FIRST   = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_cfg_err
      $error("dmem_responder: WAIT_CYCLES must be within 0..15");
   end

   state_t      state_q, state_d;
   logic        alive_q;
   logic [3:0]  cnt_q;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        gnt, rvalid, accept, acc_err;
   logic [N-1:0] idx;

   logic [31:0] mem [2**N];

   assign accept  = bus.req_i & gnt;
   assign idx     = cap_addr[N+1:2];
   assign acc_err = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (N+2)) != 32'd0);

   // alive_q keeps gnt low until the first edge after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = FIRST;
         S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP: begin
`ifdef DMEM_BACK2BACK_EN
            state_d = accept ? FIRST : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gnt    = 1'b0;
      rvalid = 1'b0;
      case (state_q)
         S_IDLE: gnt = alive_q;
         S_RESP: begin
            rvalid = 1'b1;
`ifdef DMEM_BACK2BACK_EN
            gnt    = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
         cap_be    <= 4'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q     <= WAIT_LD;
            cap_we    <= bus.we_i;
            cap_addr  <= bus.addr_i;
            cap_wdata <= bus.wdata_i;
            cap_be    <= bus.be_i;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
         end
         // response registers hold until the next ACCESS
         if (state_q == S_ACCESS) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || cap_we) ? 32'd0 : mem[idx];
         end
      end
   end

   // array is not reset; a reset drops state to IDLE so a pending write never lands
   always_ff @(posedge clk) begin
      if (state_q == S_ACCESS && cap_we && !acc_err) begin
         for (int k = 0; k < 4; k++) begin
            if (cap_be[k]) mem[idx][8*k +: 8] <= cap_wdata[8*k +: 8];
         end
      end
   end

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid;
   assign bus.rdata_o  = rdata_q;
   assign bus.err_o    = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: u_dut1 runs WAIT_CYCLES=1, u_dut0 runs WAIT_CYCLES=0 for the held-request test.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

`ifdef DMEM_BACK2BACK_EN
   localparam int PER0 = 2;
`else
   localparam int PER0 = 3;
`endif

   logic        req0 = 1'b0, req1 = 1'b0, t_we = 1'b0;
   logic [31:0] t_addr = 32'd0, t_wdata = 32'd0;
   logic [3:0]  t_be = 4'd0;

   dmem_responder_if b1();
   dmem_responder_if b0();

   assign b1.req_i = req1;  assign b0.req_i = req0;
   assign b1.we_i = t_we;   assign b0.we_i = t_we;
   assign b1.addr_i = t_addr;   assign b0.addr_i = t_addr;
   assign b1.wdata_i = t_wdata; assign b0.wdata_i = t_wdata;
   assign b1.be_i = t_be;   assign b0.be_i = t_be;

   dmem_responder #(.N(10), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   dmem_responder #(.N(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t q1[$], q0[$];
   exp_t e1, e0;
   int   checks = 0, errors = 0, cyc = 0;
   logic pv1 = 1'b0, pv0 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (b1.rvalid_o) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp1_unexpected: got rvalid expected none (t=%0t)", $time);
         end else begin
            e1 = q1.pop_front();
            chk("rsp1_rdata", b1.rdata_o, e1.rdata);
            chk("rsp1_err", {31'd0, b1.err_o}, {31'd0, e1.err});
            chk("rsp1_latency", 32'(cyc - e1.acc), 32'd3);
         end
         chk("rsp1_single_pulse", {31'd0, pv1}, 32'd0);
      end
      pv1 = b1.rvalid_o;
   end

   always @(negedge clk) begin
      if (b0.rvalid_o) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp0_unexpected: got rvalid expected none (t=%0t)", $time);
         end else begin
            e0 = q0.pop_front();
            chk("rsp0_rdata", b0.rdata_o, e0.rdata);
            chk("rsp0_err", {31'd0, b0.err_o}, {31'd0, e0.err});
            chk("rsp0_latency", 32'(cyc - e0.acc), 32'd2);
         end
         chk("rsp0_single_pulse", {31'd0, pv0}, 32'd0);
      end
      pv0 = b0.rvalid_o;
   end

   task automatic push(input bit sel, input logic [31:0] er, input bit ee);
      exp_t e;
      e.rdata = er; e.err = ee; e.acc = cyc;
      if (sel) q1.push_back(e); else q0.push_back(e);
   endtask

   // call at a negedge; returns at a negedge with req dropped
   task automatic do_req(input bit sel, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input bit ee);
      int n = 0;
      t_we = we; t_addr = a; t_wdata = wd; t_be = be;
      if (sel) req1 = 1'b1; else req0 = 1'b1;
      while (!(sel ? b1.gnt_o : b0.gnt_o) && n < 50) begin
         @(negedge clk); n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL grant_timeout: got no gnt expected gnt within 50 cycles (addr %h)", a);
      end else begin
         push(sel, er, ee);
      end
      @(negedge clk);
      req1 = 1'b0; req0 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q1.size() != 0 || q0.size() != 0) && n < 100) begin
         @(negedge clk); n++;
      end
      chk("drain_pending", 32'(q1.size() + q0.size()), 32'd0);
   endtask

   logic [31:0] vals [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

   initial begin
      int n, prev;
      repeat (3) @(negedge clk);
      chk("reset_gnt1", {31'd0, b1.gnt_o}, 32'd0);
      chk("reset_rvalid1", {31'd0, b1.rvalid_o}, 32'd0);
      chk("reset_rdata1", b1.rdata_o, 32'd0);
      chk("reset_err1", {31'd0, b1.err_o}, 32'd0);
      chk("reset_gnt0", {31'd0, b0.gnt_o}, 32'd0);
      rst = 1'b1;
      #1 chk("gnt_before_first_edge", {31'd0, b1.gnt_o}, 32'd0);
      @(negedge clk);
      chk("gnt_after_first_edge", {31'd0, b1.gnt_o}, 32'd1);

      // write/read round trip
      do_req(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 0);
      do_req(1, 0, 32'h10, 32'd0,        4'hF, 32'hDEADBEEF, 0);
      // partial byte write
      do_req(1, 1, 32'h20, 32'h11223344, 4'hF, 32'd0, 0);
      do_req(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0, 0);
      do_req(1, 0, 32'h20, 32'd0,        4'h0, 32'h11BB33DD, 0);
      // misaligned and out-of-range accesses
      do_req(1, 0, 32'h22,   32'd0, 4'hF, 32'd0, 1);
      do_req(1, 0, 32'h1000, 32'd0, 4'hF, 32'd0, 1);
      do_req(1, 0, 32'h20,   32'd0, 4'hF, 32'h11BB33DD, 0);
      // zero byte-enable write, and an out-of-range write aliasing the same index
      do_req(1, 1, 32'h40,   32'h12345678, 4'hF, 32'd0, 0);
      do_req(1, 1, 32'h40,   32'hFFFFFFFF, 4'h0, 32'd0, 0);
      do_req(1, 1, 32'h1040, 32'h0BADF00D, 4'hF, 32'd0, 1);
      do_req(1, 0, 32'h40,   32'd0,        4'hF, 32'h12345678, 0);

      // reset during WAIT of a write
      do_req(1, 1, 32'h30, 32'd0, 4'hF, 32'd0, 0);
      do_req(1, 0, 32'h20, 32'd0, 4'hF, 32'h11BB33DD, 0);
      drain();
      t_we = 1'b1; t_addr = 32'h30; t_wdata = 32'hFFFFFFFF; t_be = 4'hF; req1 = 1'b1;
      chk("gnt_before_abort", {31'd0, b1.gnt_o}, 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_gnt", {31'd0, b1.gnt_o}, 32'd0);
      chk("abort_rvalid", {31'd0, b1.rvalid_o}, 32'd0);
      chk("abort_rdata", b1.rdata_o, 32'd0);
      chk("abort_err", {31'd0, b1.err_o}, 32'd0);
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_req(1, 0, 32'h30, 32'd0, 4'hF, 32'd0, 0);

      // held request on the zero-wait instance
      for (int i = 0; i < 4; i++) do_req(0, 1, 32'(i * 4), vals[i], 4'hF, 32'd0, 0);
      t_we = 1'b0; t_be = 4'hF; req0 = 1'b1; prev = 0;
      for (int i = 0; i < 4; i++) begin
         t_addr = 32'(i * 4);
         n = 0;
         while (!b0.gnt_o && n < 20) begin
            @(negedge clk); n++;
         end
         if (n >= 20) begin
            checks++; errors++;
            $display("FAIL held_grant_timeout: got no gnt expected gnt (read %0d)", i);
         end else begin
            push(0, vals[i], 0);
            if (i > 0) chk("gnt_period", 32'(cyc - prev), 32'(PER0));
            prev = cyc;
         end
         @(negedge clk);
      end
      req0 = 1'b0;

      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's load/store port.
- Accepts one request at a time over a req/gnt handshake and inserts a parameterised number of wait states.
- Performs byte-masked writes or word reads on an internal word array, then returns a single-cycle response with rdata/err.
- Sits between the core's memory stage and the word storage; replaces the fixed single-cycle data path when variable latency is needed.

Parameters:
- N, 10, word-address width; array depth 2**N 32-bit words, byte address range 0 .. 4*2**N-1.
- WAIT_CYCLES, 1, wait states between accept and response (0..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid from core.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables; be_i[k] covers wdata_i[8k+7:8k].
- gnt_o  out  1  request accepted this cycle when req_i & gnt_o.
- rvalid_o  out  1  one-cycle response strobe.
- rdata_o  out  32  read data, valid with rvalid_o.
- err_o  out  1  access error, valid with rvalid_o.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. Array contents are not reset.
- After reset release, gnt_o is 1 in IDLE from the first clock edge onward.
- Reset mid-operation: the captured request is discarded; no array write occurs unless the write edge has already passed.

FSM states:
- IDLE: gnt_o=1. On req_i=1, capture we/addr/wdata/be, load counter=WAIT_CYCLES, then go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- WAIT: gnt_o=0. Decrement counter; go to ACCESS when counter reaches 1.
- ACCESS: gnt_o=0. Check the captured address:
  - Error condition: addr[1:0]!=0, or addr[31:N+2]!=0.
  - On error: no write; set err=1, rdata=0.
  - Else, write: update each byte k where be[k]=1; be=0 writes nothing; rdata=0.
  - Else, read: rdata = array[addr[N+1:2]], full word, be ignored.
  - Go to RESP.
- RESP: rvalid_o=1 for exactly one cycle, with rdata_o/err_o registered. Go to IDLE.
- rdata_o and err_o hold their values until the next RESP; rvalid_o=0 outside RESP.

Latency:
- Accept edge to rvalid_o high = WAIT_CYCLES+2 cycles.
- Throughput: one transaction per WAIT_CYCLES+3 cycles.

Other rules:
- req_i is ignored while gnt_o=0; the core must hold the request until granted.
- A read after a write to the same word returns the new data; the write completes in ACCESS before any later ACCESS.
- Counter is 4 bits wide. WAIT_CYCLES>15 is a configuration error and is flagged by an elaboration-time assertion.

Optional Feature:
- Macro: DMEM_BACK2BACK_EN.
- Enabled:
  - gnt_o is also 1 in RESP.
  - A request accepted in RESP is captured and goes directly to WAIT/ACCESS; IDLE is skipped.
  - Throughput becomes one transaction per WAIT_CYCLES+2 cycles.
  - Latency is unchanged.
- Disabled: gnt_o=1 only in IDLE, exactly as in Behaviour.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 (WAIT_CYCLES=1) -> rvalid_o 3 cycles after each accept; read rdata_o=0xDEADBEEF, err_o=0.
2. Word 0x20 preloaded with 0x11223344; write wdata=0xAABBCCDD, be=4'b0101; read back -> 0x11BB33DD.
3. Read at 0x22 (misaligned), and read at 4*2**N (out of range) -> err_o=1, rdata_o=0; the following in-range read of 0x20 returns unchanged data.
4. Hold req_i=1 continuously with 4 reads, WAIT_CYCLES=0 -> gnt_o pulses every 3 cycles (every 2 cycles with DMEM_BACK2BACK_EN); each rvalid_o is exactly 1 cycle.
5. Assert rst=0 asynchronously mid-WAIT of a write to 0x30 (old value 0x0) -> gnt_o/rvalid_o/rdata_o/err_o go to 0 immediately; after release a read of 0x30 returns 0x0.
6. Write with be=4'h0 to 0x40 (old value 0x12345678) -> response err_o=0; read returns 0x12345678.
